// File: rtl/mem_arbiter_if.sv
// Native valid/ready memory bus between N requesting masters and one slave.
// The arbiter binds the same instance twice: as slave to the masters, as master to the memory.
interface mem_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Handshake: a requester holds valid and its payload stable until it sees ready;
  // ready is a one-cycle completion pulse, and valid in the following cycle is a new request.
  logic [NUM_MASTERS-1:0]        m_valid;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb;
  logic [NUM_MASTERS-1:0]        m_ready;
  logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
  logic [NUM_MASTERS-1:0]        m_err;

  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;

  modport slave  (input  m_valid, m_addr, m_wdata, m_wstrb,
                  output m_ready, m_rdata, m_err);
  modport master (output s_valid, s_addr, s_wdata, s_wstrb,
                  input  s_ready, s_rdata);
endinterface

// File: rtl/mem_arbiter.sv
// N-master to 1-slave round-robin arbiter for the native valid/ready memory bus,
// with an optional watchdog that completes stalled transactions with an error flag.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  m_bus,
  mem_arbiter_if.master s_bus,
  output logic          o_busy
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_grant_idx, w_grant_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0] w_pick, w_cand, w_grant_inc;
  logic [IDX_W:0]   w_sum;
  logic             w_any_req;
  logic             w_timeout;

  assign o_busy      = (r_state == BUSY);
  assign w_grant_inc = (r_grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_grant_idx + IDX_W'(1);

  // Walk offsets from the far end down so the closest requester at or after rr_ptr wins.
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = r_rr_ptr;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_MASTERS)) w_sum = w_sum - (IDX_W+1)'(NUM_MASTERS);
      w_cand = w_sum[IDX_W-1:0];
      if (m_bus.m_valid[w_cand]) begin
        w_any_req = 1'b1;
        w_pick    = w_cand;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      logic [CNT_W-1:0] r_wd_cnt;

      assign w_timeout = (r_state == BUSY) && !s_bus.s_ready &&
                         (r_wd_cnt == CNT_W'(TIMEOUT - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wd_cnt <= '0;
        end else if (r_state == BUSY && !s_bus.s_ready && !w_timeout) begin
          if (r_wd_cnt != '1) r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end else begin
          r_wd_cnt <= '0;
        end
      end
    end else begin : g_no_wdog
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant_idx;
    w_rr_nxt        = r_rr_ptr;
    s_bus.s_valid   = 1'b0;
    s_bus.s_addr    = '0;
    s_bus.s_wdata   = '0;
    s_bus.s_wstrb   = '0;
    m_bus.m_ready   = '0;
    m_bus.m_rdata   = '0;
    m_bus.m_err     = '0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_pick;
        end
      end
      BUSY: begin
        s_bus.s_valid = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (r_grant_idx == IDX_W'(i)) begin
            s_bus.s_addr  = m_bus.m_addr[i*ADDR_W +: ADDR_W];
            s_bus.s_wdata = m_bus.m_wdata[i*DATA_W +: DATA_W];
            s_bus.s_wstrb = m_bus.m_wstrb[i*STRB_W +: STRB_W];
            m_bus.m_ready[i] = s_bus.s_ready | w_timeout;
            m_bus.m_err[i]   = w_timeout;
            // A timed-out response carries no data even if the slave drives some.
            m_bus.m_rdata[i*DATA_W +: DATA_W] = w_timeout ? '0 : s_bus.s_rdata;
          end
        end
        if (s_bus.s_ready || w_timeout) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_grant_inc;
        end
      end
      default: ;
    endcase
  end
endmodule
